// File: rtl/chipmunk_run_ctrl.sv
// Chipmunk run controller: loads a program image, runs the CPU, then streams a result window back.
// Optional watchdog on the run-cycle counter is enabled by defining CHIPMUNK_WATCHDOG_EN.
module chipmunk_run_ctrl #(
  parameter int ADDR_SIZE = 12,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] load_base,
  input  logic [ADDR_SIZE-1:0] load_len,
  input  logic [ADDR_SIZE-1:0] dump_base,
  input  logic [ADDR_SIZE-1:0] dump_len,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  logic [7:0]           host_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 cpu_reset_n,
  input  logic                 cpu_done,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [7:0]           cpu_wdata,
  input  logic                 cpu_we_n,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we_n,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 timeout,
  output logic [TIMEOUT_W-1:0] run_cycles,
  output logic [2:0]           dbgState
);

  // Handshakes: a byte moves on any cycle where valid and ready are both high at the
  // rising clk edge; a source holds valid and data steady until that cycle.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DUMP = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(1);
  localparam logic [TIMEOUT_W-1:0] RUN_ONE  = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] RUN_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state;
  state_t               stateNext;
  logic [ADDR_SIZE-1:0] loadPtr;
  logic [ADDR_SIZE-1:0] dumpPtr;
  logic [ADDR_SIZE-1:0] remaining;
  logic [ADDR_SIZE-1:0] dumpLenQ;
  logic                 loadHs;
  logic                 dumpLoad;
  logic                 outHs;
  logic                 runSat;
  logic                 wdFire;
  logic                 runExit;

  assign loadHs   = (state == LOAD) && host_valid;
  assign outHs    = out_valid && out_ready;
  assign dumpLoad = (state == DUMP) && (remaining != '0) && (!out_valid || out_ready);
  assign runSat   = &run_cycles;
  assign dbgState = state;

`ifdef CHIPMUNK_WATCHDOG_EN
  // Fires on the RUN cycle that brings run_cycles to all-ones; a same-cycle done wins.
  assign wdFire = (state == RUN) && !cpu_done && (run_cycles >= RUN_LAST);
`else
  assign wdFire = 1'b0;
`endif

  assign runExit = (state == RUN) && (cpu_done || wdFire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext   = state;
    host_ready  = 1'b0;
    cpu_reset_n = 1'b0;
    busy        = 1'b1;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we_n    = 1'b1;
    case (state)
      IDLE, DONE: begin
        busy = 1'b0;
        if (start) begin
          stateNext = (load_len == '0) ? RUN : LOAD;
        end
      end
      LOAD: begin
        host_ready = 1'b1;
        mem_addr   = loadPtr;
        mem_wdata  = host_data;
        // Strobe only in the low phase so address and data are settled around it.
        mem_we_n   = !(host_valid && !clk);
        if (loadHs && (remaining == ADDR_ONE)) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        cpu_reset_n = 1'b1;
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;
        mem_we_n    = cpu_we_n;
        if (runExit) begin
          stateNext = (dumpLenQ == '0) ? DONE : DUMP;
        end
      end
      DUMP: begin
        mem_addr = dumpPtr;
        if ((remaining == '0) && outHs) begin
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loadPtr    <= '0;
      dumpPtr    <= '0;
      remaining  <= '0;
      dumpLenQ   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      timeout    <= 1'b0;
      run_cycles <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            loadPtr    <= load_base;
            dumpPtr    <= dump_base;
            remaining  <= load_len;
            dumpLenQ   <= dump_len;
            timeout    <= 1'b0;
            run_cycles <= '0;
          end
        end
        LOAD: begin
          if (loadHs) begin
            loadPtr   <= loadPtr + ADDR_ONE;
            remaining <= remaining - ADDR_ONE;
          end
        end
        RUN: begin
          if (!runSat) begin
            run_cycles <= run_cycles + RUN_ONE;
          end
          if (wdFire) begin
            timeout <= 1'b1;
          end
          if (runExit) begin
            remaining <= dumpLenQ;
          end
        end
        DUMP: begin
          // Reload whenever the output register is empty or draining this cycle.
          if (dumpLoad) begin
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
            dumpPtr   <= dumpPtr + ADDR_ONE;
            remaining <= remaining - ADDR_ONE;
          end else if (outHs) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
